lcd_panel_seq: RTL

- Power-up/re-scan sequencer for the RGB LCD path.
- After reset it holds the RGB bus tri-stated and waits for the panel ID straps to settle. It samples M2/M1/M0 (B7/G7/R7) with a stability filter and decodes the panel ID plus active resolution.
- It then sequences panel reset, RGB output enable, timing-generator enable and backlight.
- Sits between the RGB pad buffers and the LCD timing generator / framebuffer reader. It is the only block that drives rgb_oe.

---
 rtl/lcd_pkg.sv | 60 ++++++
 rtl/lcd_strap_filter.sv | 60 ++++++
 rtl/lcd_panel_seq.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Purpose: shared constants, state encoding and strap decode for the LCD power-up sequencer.
// Latency: n/a (package only).
// Backpressure: n/a.
package lcd_pkg;

  // Strap codes as {B7, G7, R7}
  localparam logic [2:0] CODE_4342    = 3'b000;
  localparam logic [2:0] CODE_7084    = 3'b001;
  localparam logic [2:0] CODE_7016    = 3'b010;
  localparam logic [2:0] CODE_4384    = 3'b100;
  localparam logic [2:0] CODE_1018    = 3'b101;
  localparam logic [2:0] CODE_DEFAULT = CODE_7084;

  localparam logic [15:0] ID_4342 = 16'h4342;
  localparam logic [15:0] ID_7084 = 16'h7084;
  localparam logic [15:0] ID_7016 = 16'h7016;
  localparam logic [15:0] ID_4384 = 16'h4384;
  localparam logic [15:0] ID_1018 = 16'h1018;

  localparam logic [10:0] RES_272  = 11'd272;
  localparam logic [10:0] RES_480  = 11'd480;
  localparam logic [10:0] RES_600  = 11'd600;
  localparam logic [10:0] RES_800  = 11'd800;
  localparam logic [10:0] RES_1024 = 11'd1024;
  localparam logic [10:0] RES_1280 = 11'd1280;

  localparam int CNT_W = 17;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    ST_SETTLE, ST_SAMPLE, ST_DECODE, ST_PRST, ST_OE_ON, ST_TGEN_ON, ST_RUN
  } lcd_state_e;

  typedef struct packed {
    logic [15:0] id;
    logic [10:0] h;
    logic [10:0] v;
    logic        mapped;
  } panel_cfg_t;

  // Unmapped codes fall back to the 7084 panel with mapped = 0.
  function automatic panel_cfg_t lcd_decode(input logic [2:0] code);
    panel_cfg_t c;
    c = '{id: ID_7084, h: RES_800, v: RES_480, mapped: 1'b0};
    case (code)
      CODE_4342: c = '{id: ID_4342, h: RES_480,  v: RES_272, mapped: 1'b1};
      CODE_7084: c = '{id: ID_7084, h: RES_800,  v: RES_480, mapped: 1'b1};
      CODE_7016: c = '{id: ID_7016, h: RES_1024, v: RES_600, mapped: 1'b1};
      CODE_4384: c = '{id: ID_4384, h: RES_800,  v: RES_480, mapped: 1'b1};
      CODE_1018: c = '{id: ID_1018, h: RES_1280, v: RES_800, mapped: 1'b1};
      default: ;
    endcase
    return c;
  endfunction

  function automatic cnt_t sat_inc(input cnt_t v);
    return (&v) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/lcd_strap_filter.sv
// Purpose: synchronises the 3 panel-ID straps and qualifies them with a stability count and a sample timeout.
// Latency: 2 clk synchroniser, then done after STABLE_CNT identical samples while en is high.
// Backpressure: none; counters clear whenever en is low.
// Ports: strap_raw (async straps) / en (sampling window) in; code, done, timeout out (combinational from flops).
module lcd_strap_filter
  import lcd_pkg::*;
#(
  parameter int unsigned STABLE_CNT  = 16,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] strap_raw,
  input  logic       en,
  output logic [2:0] code,
  output logic       done,
  output logic       timeout
);

  localparam cnt_t STAB_LIM = cnt_t'(STABLE_CNT);
  localparam cnt_t TMO_LIM  = cnt_t'(TIMEOUT_CYC);

  logic [2:0] sync1_q, sync2_q, prev_q, prev_d;
  cnt_t       stab_q, stab_d, smp_q, smp_d;

  always_comb begin
    prev_d = prev_q;
    stab_d = '0;
    smp_d  = '0;
    if (en) begin
      prev_d = sync2_q;
      smp_d  = sat_inc(smp_q);
      // First sample of a window has nothing to compare against, so it counts as 1.
      if (stab_q != '0 && sync2_q == prev_q) stab_d = sat_inc(stab_q);
      else                                   stab_d = cnt_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      stab_q  <= '0;
      smp_q   <= '0;
    end else begin
      sync1_q <= strap_raw;
      sync2_q <= sync1_q;
      prev_q  <= prev_d;
      stab_q  <= stab_d;
      smp_q   <= smp_d;
    end
  end

  // A code that becomes stable on the last allowed sample still wins over the timeout.
  assign code    = prev_q;
  assign done    = en && (stab_q >= STAB_LIM);
  assign timeout = en && !done && (smp_q >= TMO_LIM);

endmodule

// File: rtl/lcd_panel_seq.sv
// Purpose: power-up / re-scan sequencer: strap sampling, panel ID decode, panel reset, RGB OE, tgen and backlight.
// Latency: ready ~ SETTLE+2+STABLE+1+PRST+1+BL_DLY clk after reset; all outputs registered.
// Backpressure: none; rescan (any state but SETTLE) drops all enables on the next edge and restarts.
// Ports: clk, rst_n, lcd_rgb_in[23/15/7] straps, rescan in; rgb_oe, lcd_rst_n, tgen_en, lcd_bl,
//        lcd_id, h_disp, v_disp, id_valid, id_fault, ready out.
// Build option: define LCD_ID_FORCE_EN to skip strap sampling and decode FORCE_CODE instead.
module lcd_panel_seq
  import lcd_pkg::*;
#(
  parameter int unsigned SETTLE_CYC  = 1000,
  parameter int unsigned STABLE_CNT  = 16,
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter int unsigned PRST_CYC    = 2000,
  parameter int unsigned BL_DLY_CYC  = 50000
`ifdef LCD_ID_FORCE_EN
  , parameter logic [2:0] FORCE_CODE = 3'b001
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] lcd_rgb_in,
  input  logic        rescan,
  output logic        rgb_oe,
  output logic        lcd_rst_n,
  output logic        tgen_en,
  output logic        lcd_bl,
  output logic [15:0] lcd_id,
  output logic [10:0] h_disp,
  output logic [10:0] v_disp,
  output logic        id_valid,
  output logic        id_fault,
  output logic        ready
);

  localparam cnt_t SETTLE_LIM = cnt_t'(SETTLE_CYC - 1);
  localparam cnt_t PRST_LIM   = cnt_t'(PRST_CYC - 1);
  localparam cnt_t BL_LIM     = cnt_t'(BL_DLY_CYC - 1);

  lcd_state_e  state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic        rgb_oe_q, rgb_oe_d, lcd_rst_n_q, lcd_rst_n_d, tgen_en_q, tgen_en_d;
  logic        lcd_bl_q, lcd_bl_d, ready_q, ready_d, id_valid_q, id_valid_d, id_fault_q, id_fault_d;
  logic [15:0] lcd_id_q, lcd_id_d;
  logic [10:0] h_disp_q, h_disp_d, v_disp_q, v_disp_d;
  logic [2:0]  dec_code;
  logic        dec_load, dec_fault;
  panel_cfg_t  cfg;

`ifdef LCD_ID_FORCE_EN
  logic unused_pad;
  assign unused_pad = ^lcd_rgb_in;
`else
  logic [2:0] flt_code;
  logic       flt_done, flt_timeout;
  logic       unused_pad;
  assign unused_pad = ^{lcd_rgb_in[22:16], lcd_rgb_in[14:8], lcd_rgb_in[6:0]};

  lcd_strap_filter #(
    .STABLE_CNT (STABLE_CNT),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .strap_raw({lcd_rgb_in[7], lcd_rgb_in[15], lcd_rgb_in[23]}),
    .en       (state_q == ST_SAMPLE),
    .code     (flt_code),
    .done     (flt_done),
    .timeout  (flt_timeout)
  );
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = sat_inc(cnt_q);
    id_valid_d = id_valid_q;
    id_fault_d = id_fault_q;
    lcd_id_d   = lcd_id_q;
    h_disp_d   = h_disp_q;
    v_disp_d   = v_disp_q;
    dec_code   = CODE_DEFAULT;
    dec_load   = 1'b0;
    dec_fault  = 1'b0;

    case (state_q)
      ST_SETTLE: if (cnt_q >= SETTLE_LIM) begin
        cnt_d = '0;
`ifdef LCD_ID_FORCE_EN
        state_d  = ST_DECODE;
        dec_load = 1'b1;
        dec_code = FORCE_CODE;
`else
        state_d  = ST_SAMPLE;
`endif
      end
`ifndef LCD_ID_FORCE_EN
      ST_SAMPLE: begin
        if (flt_done) begin
          state_d  = ST_DECODE;
          dec_load = 1'b1;
          dec_code = flt_code;
        end else if (flt_timeout) begin
          state_d   = ST_DECODE;
          dec_load  = 1'b1;
          dec_fault = 1'b1;
        end
      end
`endif
      ST_DECODE: begin
        state_d = ST_PRST;
        cnt_d   = '0;
      end
      ST_PRST: if (cnt_q >= PRST_LIM) begin
        state_d = ST_OE_ON;
        cnt_d   = '0;
      end
      ST_OE_ON: begin
        state_d = ST_TGEN_ON;
        cnt_d   = '0;
      end
      ST_TGEN_ON: if (cnt_q >= BL_LIM) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
      ST_RUN: ;
      default: begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
      end
    endcase

    // Decoded values are registered on entry to DECODE so id_valid leads rgb_oe by a full PRST window.
    cfg = lcd_decode(dec_code);
    if (rescan && state_q != ST_SETTLE) begin
      state_d    = ST_SETTLE;
      cnt_d      = '0;
      id_valid_d = 1'b0;
      id_fault_d = 1'b0;
    end else if (dec_load) begin
      lcd_id_d   = cfg.id;
      h_disp_d   = cfg.h;
      v_disp_d   = cfg.v;
      id_valid_d = 1'b1;
      id_fault_d = dec_fault | ~cfg.mapped;
    end

    // Enables are a pure function of the next state, so they all drop on the same edge as a rescan.
    lcd_rst_n_d = state_d inside {ST_OE_ON, ST_TGEN_ON, ST_RUN};
    rgb_oe_d    = state_d inside {ST_OE_ON, ST_TGEN_ON, ST_RUN};
    tgen_en_d   = state_d inside {ST_TGEN_ON, ST_RUN};
    lcd_bl_d    = (state_d == ST_RUN);
    ready_d     = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SETTLE;
      cnt_q       <= '0;
      rgb_oe_q    <= 1'b0;
      lcd_rst_n_q <= 1'b0;
      tgen_en_q   <= 1'b0;
      lcd_bl_q    <= 1'b0;
      ready_q     <= 1'b0;
      id_valid_q  <= 1'b0;
      id_fault_q  <= 1'b0;
      lcd_id_q    <= '0;
      h_disp_q    <= '0;
      v_disp_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rgb_oe_q    <= rgb_oe_d;
      lcd_rst_n_q <= lcd_rst_n_d;
      tgen_en_q   <= tgen_en_d;
      lcd_bl_q    <= lcd_bl_d;
      ready_q     <= ready_d;
      id_valid_q  <= id_valid_d;
      id_fault_q  <= id_fault_d;
      lcd_id_q    <= lcd_id_d;
      h_disp_q    <= h_disp_d;
      v_disp_q    <= v_disp_d;
    end
  end

  assign rgb_oe    = rgb_oe_q;
  assign lcd_rst_n = lcd_rst_n_q;
  assign tgen_en   = tgen_en_q;
  assign lcd_bl    = lcd_bl_q;
  assign ready     = ready_q;
  assign id_valid  = id_valid_q;
  assign id_fault  = id_fault_q;
  assign lcd_id    = lcd_id_q;
  assign h_disp    = h_disp_q;
  assign v_disp    = v_disp_q;

endmodule
